// File: rtl/msi_cpu_side_ctrl.sv
// Processor-side MSI controller: tags + line states for a direct-mapped cache, CPU requests -> bus messages.
// Hit completes 2 cycles after request; misses hold bus_req until grant; snoops applied in any state.
module msi_cpu_side_ctrl #(
  parameter int NUM_LINES = 4,
  parameter int TAG_W     = 4,
  localparam int INDEX_W  = $clog2(NUM_LINES),
  localparam int AW       = TAG_W + INDEX_W
) (
  input  logic          clock_i,
  input  logic          resetn_i,
  input  logic          cpu_req_i,
  input  logic          cpu_we_i,
  input  logic [AW-1:0] cpu_addr_i,
  output logic          cpu_busy_o,
  output logic          cpu_done_o,
  output logic          cpu_hit_o,
  output logic          bus_req_o,
  input  logic          bus_gnt_i,
  output logic [1:0]    bus_op_o,
  output logic [AW-1:0] bus_addr_o,
  output logic          bus_wb_o,
  input  logic          snoop_valid_i,
  input  logic [1:0]    snoop_op_i,
  input  logic [AW-1:0] snoop_addr_i,
  output logic          snoop_wb_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_CHECK, ST_REQ, ST_DONE} state_e;

  localparam logic [1:0] LS_I   = 2'b00;
  localparam logic [1:0] LS_E   = 2'b01;
  localparam logic [1:0] LS_S   = 2'b10;
  localparam logic [1:0] OP_RM  = 2'b00;
  localparam logic [1:0] OP_INV = 2'b01;
  localparam logic [1:0] OP_WM  = 2'b10;

  state_e             state_q, state_d;
  logic               we_q, we_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic [1:0]         op_q, op_d;
  logic               wb_q, wb_d;
  logic               hit_q, hit_d;
  logic               snoop_wb_q, snoop_wb_d;
  logic [1:0]         lstate_q [NUM_LINES];
  logic [1:0]         lstate_d [NUM_LINES];
  logic [TAG_W-1:0]   ltag_q   [NUM_LINES];
  logic [TAG_W-1:0]   ltag_d   [NUM_LINES];

  logic [INDEX_W-1:0] req_idx, snp_idx;
  logic [TAG_W-1:0]   req_tag, snp_tag;
  logic               snp_match, line_hit;
  logic [1:0]         cur_ls;

  assign req_idx = addr_q[INDEX_W-1:0];
  assign req_tag = addr_q[AW-1:INDEX_W];
  assign snp_idx = snoop_addr_i[INDEX_W-1:0];
  assign snp_tag = snoop_addr_i[AW-1:INDEX_W];

  // A snoop coinciding with a grant is dropped; the grant owns the line update that cycle.
  assign snp_match = snoop_valid_i && !bus_gnt_i &&
                     (lstate_q[snp_idx] != LS_I) && (ltag_q[snp_idx] == snp_tag);

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    addr_d     = addr_q;
    op_d       = op_q;
    wb_d       = wb_q;
    hit_d      = hit_q;
    snoop_wb_d = 1'b0;
    lstate_d   = lstate_q;
    ltag_d     = ltag_q;
    cur_ls     = LS_I;
    line_hit   = 1'b0;

    if (snp_match) begin
      if (lstate_q[snp_idx] == LS_E) begin
        if (snoop_op_i == OP_RM) begin
          lstate_d[snp_idx] = LS_S;
          snoop_wb_d        = 1'b1;
        end else if (snoop_op_i == OP_INV || snoop_op_i == OP_WM) begin
          lstate_d[snp_idx] = LS_I;
          snoop_wb_d        = 1'b1;
        end
      end else if (snoop_op_i == OP_INV || snoop_op_i == OP_WM) begin
        lstate_d[snp_idx] = LS_I;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (cpu_req_i) begin
          we_d    = cpu_we_i;
          addr_d  = cpu_addr_i;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        // Decide on the post-snoop view so a same-cycle snoop cannot leave a stale upgrade or writeback.
        cur_ls   = lstate_d[req_idx];
        line_hit = (cur_ls != LS_I) && (ltag_d[req_idx] == req_tag);
        if (line_hit && (!we_q || cur_ls == LS_E)) begin
          hit_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          hit_d   = 1'b0;
          state_d = ST_REQ;
          if (line_hit) begin
            op_d = OP_INV;
            wb_d = 1'b0;
          end else begin
            op_d = we_q ? OP_WM : OP_RM;
            wb_d = (cur_ls == LS_E);
          end
        end
      end
      ST_REQ: begin
        if (bus_gnt_i) begin
          ltag_d[req_idx]   = req_tag;
          lstate_d[req_idx] = (op_q == OP_RM) ? LS_S : LS_E;
          state_d           = ST_DONE;
        end else if (snp_match && snp_idx == req_idx) begin
          if (op_q == OP_INV && lstate_d[req_idx] == LS_I) op_d = OP_WM;
          if (wb_q && lstate_d[req_idx] != LS_E) wb_d = 1'b0;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (!resetn_i) begin
      state_q    <= ST_IDLE;
      we_q       <= 1'b0;
      addr_q     <= '0;
      op_q       <= OP_RM;
      wb_q       <= 1'b0;
      hit_q      <= 1'b0;
      snoop_wb_q <= 1'b0;
      for (int i = 0; i < NUM_LINES; i++) begin
        lstate_q[i] <= LS_I;
        ltag_q[i]   <= '0;
      end
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      op_q       <= op_d;
      wb_q       <= wb_d;
      hit_q      <= hit_d;
      snoop_wb_q <= snoop_wb_d;
      lstate_q   <= lstate_d;
      ltag_q     <= ltag_d;
    end
  end

  assign cpu_busy_o = (state_q != ST_IDLE);
  assign cpu_done_o = (state_q == ST_DONE);
  assign cpu_hit_o  = (state_q == ST_DONE) && hit_q;
  assign bus_req_o  = (state_q == ST_REQ);
  assign bus_op_o   = op_q;
  assign bus_addr_o = addr_q;
  assign bus_wb_o   = wb_q;
  assign snoop_wb_o = snoop_wb_q;

endmodule
